// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer feeding the 1000 sequence detector.
// ST_PARITY is only reachable when BIT_SERIALIZER_PARITY_EN is defined.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Words up to 64 bits wide are zero-extended by the caller before this is applied.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bit_serializer_hold.sv
// One-entry holding register between the word handshake and the shifter.
// A load and a drain on the same edge replace the stored word and keep the entry full.
module bit_serializer_hold
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    logic [WIDTH-1:0] data_r;
    logic             full_r;

    // Buffer storage and occupancy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {WIDTH{1'b0}};
            full_r <= 1'b0;
        end else if (load) begin
            data_r <= din;
            full_r <= 1'b1;
        end else if (drain) begin
            full_r <= 1'b0;
        end
    end

    assign dout = data_r;
    assign full = full_r;

endmodule

// File: rtl/bit_serializer_tx.sv
// Parallel-to-serial transmitter with a one-word holding buffer for gapless streaming.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after every word.
module bit_serializer_tx
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic             x_r, x_s;
    logic             x_valid_r, x_valid_s;
    logic             word_done_r, word_done_s;
    logic             busy_r, busy_s;
    logic             in_ready_r, in_ready_s;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par_r, par_s;
`endif

    logic             accept_s;
    logic             word_end_s;
    logic             load_shift_s;
    logic [WIDTH-1:0] load_word_s;
    logic             hold_load_s;
    logic             hold_drain_s;
    logic             hold_full_s;
    logic             hold_full_next_s;
    logic [WIDTH-1:0] hold_data_s;

    bit_serializer_hold #(.WIDTH(WIDTH)) u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (hold_load_s),
        .drain (hold_drain_s),
        .din   (data_in),
        .dout  (hold_data_s),
        .full  (hold_full_s)
    );

    assign accept_s = in_valid & in_ready_r;

    // Next-state, shifter and output-bit selection.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        shreg_s      = shreg_r;
        x_s          = 1'b0;
        x_valid_s    = 1'b0;
        word_end_s   = 1'b0;
        load_shift_s = 1'b0;
        load_word_s  = {WIDTH{1'b0}};
        hold_load_s  = 1'b0;
        hold_drain_s = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_s        = par_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    load_shift_s = 1'b1;
                    load_word_s  = data_in;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == LAST_CNT) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_s     = ST_PARITY;
                    x_s         = par_r;
                    x_valid_s   = 1'b1;
                    hold_load_s = accept_s;
`else
                    word_end_s  = 1'b1;
`endif
                end else begin
                    x_s         = MSB_FIRST ? shreg_r[WIDTH-1] : shreg_r[0];
                    shreg_s     = MSB_FIRST ? {shreg_r[WIDTH-2:0], 1'b0} : {1'b0, shreg_r[WIDTH-1:1]};
                    x_valid_s   = 1'b1;
                    cnt_s       = cnt_r + CNT_W'(1);
                    hold_load_s = accept_s;
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                word_end_s = 1'b1;
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // The buffered word wins; a same-edge accept can only happen with the buffer empty.
        if (word_end_s) begin
            if (hold_full_s) begin
                hold_drain_s = 1'b1;
                hold_load_s  = accept_s;
                load_shift_s = 1'b1;
                load_word_s  = hold_hold_word(hold_data_s);
            end else if (accept_s) begin
                load_shift_s = 1'b1;
                load_word_s  = data_in;
            end else begin
                state_s = ST_IDLE;
            end
        end else begin
            hold_drain_s = 1'b0;
        end

        if (load_shift_s) begin
            state_s   = ST_SHIFT;
            cnt_s     = {CNT_W{1'b0}};
            x_s       = MSB_FIRST ? load_word_s[WIDTH-1] : load_word_s[0];
            shreg_s   = MSB_FIRST ? {load_word_s[WIDTH-2:0], 1'b0} : {1'b0, load_word_s[WIDTH-1:1]};
            x_valid_s = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_s     = even_parity(64'(load_word_s));
`endif
        end else begin
            load_shift_s = 1'b0;
        end
    end

    function automatic logic [WIDTH-1:0] hold_hold_word(input logic [WIDTH-1:0] w);
        return w;
    endfunction

    // Flags derived from the post-edge state so every output comes straight from a flop.
    always_comb begin
        hold_full_next_s = hold_load_s ? 1'b1 : (hold_drain_s ? 1'b0 : hold_full_s);
        in_ready_s       = ~hold_full_next_s;
        busy_s           = (state_s != ST_IDLE) | hold_full_next_s;
`ifdef BIT_SERIALIZER_PARITY_EN
        word_done_s      = (state_s == ST_PARITY);
`else
        word_done_s      = (state_s == ST_SHIFT) && (cnt_s == LAST_CNT);
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            shreg_r     <= {WIDTH{1'b0}};
            x_r         <= 1'b0;
            x_valid_r   <= 1'b0;
            word_done_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            shreg_r     <= shreg_s;
            x_r         <= x_s;
            x_valid_r   <= x_valid_s;
            word_done_r <= word_done_s;
            busy_r      <= busy_s;
            in_ready_r  <= in_ready_s;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_r       <= par_s;
`endif
        end
    end

    assign x         = x_r;
    assign x_valid   = x_valid_r;
    assign word_done = word_done_r;
    assign busy      = busy_r;
    assign in_ready  = in_ready_r;

endmodule

// File: tb/tb_bit_serializer_tx.sv
// Directed bench for bit_serializer_tx: MSB-first and LSB-first instances share clock and reset.
// With BIT_SERIALIZER_PARITY_EN defined it runs the reset and parity scenarios only.
module tb_bit_serializer_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in, data_in2;
    logic       in_valid, in_valid2;
    logic       in_ready, x, x_valid, word_done, busy;
    logic       in_ready2, x2, x_valid2, word_done2, busy2;

    int checks = 0;
    int errors = 0;

    bit_serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .x_valid(x_valid), .word_done(word_done), .busy(busy)
    );

    bit_serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .data_in(data_in2), .in_valid(in_valid2), .in_ready(in_ready2),
        .x(x2), .x_valid(x_valid2), .word_done(word_done2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifndef BIT_SERIALIZER_PARITY_EN
    int         det_st  = 0;
    int         det_cnt = 0;
    logic [7:0] w;
    logic [7:0] bw [3];
    int         idx, base, dones;
    logic       rdy, saw_nr;

    // Reference 1000 Moore detector fed only with qualified serial bits.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            det_st <= 0;
        end else if (x_valid) begin
            case (det_st)
                1:       det_st <= x ? 1 : 2;
                2:       det_st <= x ? 1 : 3;
                3: begin
                    if (x) begin
                        det_st <= 1;
                    end else begin
                        det_st  <= 4;
                        det_cnt <= det_cnt + 1;
                    end
                end
                default: det_st <= x ? 1 : 0;
            endcase
        end
    end
`else
    logic [8:0] pb;
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; data_in = 8'h00; in_valid2 = 1'b0; data_in2 = 8'h00;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_x", x, 0); chk("rst_xv", x_valid, 0); chk("rst_rdy", in_ready, 1);
            chk("rst_busy", busy, 0); chk("rst_done", word_done, 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_x", x, 0); chk("rel_xv", x_valid, 0); chk("rel_rdy", in_ready, 1); chk("rel_busy", busy, 0);

`ifndef BIT_SERIALIZER_PARITY_EN
        // Single 8'h88, MSB first, with detector feed.
        base = det_cnt;
        w = 8'h88;
        data_in = w; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("b88_bit", x, w[7-i]); chk("b88_xv", x_valid, 1); chk("b88_done", word_done, i == 7);
            @(posedge clk); #1;
        end
        chk("b88_idle_xv", x_valid, 0); chk("b88_idle_busy", busy, 0); chk("b88_det", det_cnt - base, 2);

        // Back-to-back stream with in_valid held high.
        bw[0] = 8'hA5; bw[1] = 8'h3C; bw[2] = 8'hF0;
        idx = 0; dones = 0; saw_nr = 1'b0;
        data_in = bw[0]; in_valid = 1'b1;
        for (int c = 0; c < 25; c++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (in_valid && rdy) begin
                idx++;
                if (idx < 3) data_in = bw[idx];
                else in_valid = 1'b0;
            end
            if (!in_ready) saw_nr = 1'b1;
            if (word_done) dones++;
            if (c < 24) begin
                w = bw[c/8];
                chk("b2b_bit", x, w[7-(c%8)]); chk("b2b_xv", x_valid, 1);
                chk("b2b_done", word_done, (c % 8) == 7);
            end else begin
                chk("b2b_end_xv", x_valid, 0);
            end
        end
        chk("b2b_not_ready_seen", saw_nr, 1); chk("b2b_dones", dones, 3); chk("b2b_accepts", idx, 3);
        chk("b2b_end_busy", busy, 0);

        // LSB-first instance with 8'h01.
        data_in2 = 8'h01; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("lsb_bit", x2, i == 0); chk("lsb_xv", x_valid2, 1); chk("lsb_done", word_done2, i == 7);
            @(posedge clk); #1;
        end
        chk("lsb_idle_xv", x_valid2, 0); chk("lsb_idle_busy", busy2, 0); chk("lsb_rdy", in_ready2, 1);

        // Reset at bit 4 of 8'hFF with a second word buffered.
        data_in = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_xv", x_valid, 1); chk("mid_x", x, 1); chk("mid_rdy", in_ready, 0); chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_xv", x_valid, 0); chk("arst_x", x, 0); chk("arst_rdy", in_ready, 1);
        chk("arst_busy", busy, 0); chk("arst_done", word_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            chk("post_xv", x_valid, 0); chk("post_busy", busy, 0); chk("post_rdy", in_ready, 1);
        end
        data_in = 8'h80; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("restart_x", x, 1); chk("restart_xv", x_valid, 1);
        repeat (8) begin @(posedge clk); #1; end
        chk("restart_idle", busy, 0);
`else
        // Parity build: 8'h07 then its even-parity bit.
        pb = 9'b0_0000_1111;
        data_in = 8'h07; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("par_bit", x, pb[8-i]); chk("par_xv", x_valid, 1); chk("par_done", word_done, i == 8);
            @(posedge clk); #1;
        end
        chk("par_idle_xv", x_valid, 0); chk("par_idle_busy", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
